// File: rtl/am_pkg.sv
// Shared encodings, latency constant and FSM state type for the AM envelope detector.
package am_pkg;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_HALF = 2'd1,
        MODE_SQR  = 2'd2,
        MODE_RSVD = 2'd3
    } am_mode_e;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } am_state_e;

    // Clocks from an accepted in_valid to its out_valid pulse.
    localparam int AM_LAT = 4;

    // The reserved encoding behaves exactly like full-wave, including for change detection.
    function automatic am_mode_e am_mode_norm(input logic [1:0] mode);
        am_mode_e m;
        m = am_mode_e'(mode);
        if (m == MODE_RSVD) begin
            m = MODE_FULL;
        end
        return m;
    endfunction

endpackage

// File: rtl/am_movavg.sv
// Moving-average core: circular buffer of 2^LOG2 samples, running sum and fill counter.
module am_movavg #(
    parameter int W    = 12,
    parameter int LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] avg_o,
    output logic         last_fill_o
);

    localparam int DEPTH = 1 << LOG2;
    localparam int SW    = W + LOG2;

    logic [W-1:0]    buf_q [DEPTH];
    logic [LOG2-1:0] wr_ptr_q;
    logic [LOG2-1:0] wr_ptr_d;
    logic [SW-1:0]   sum_q;
    logic [SW-1:0]   sum_d;
    logic [LOG2:0]   fill_cnt_q;
    logic [LOG2:0]   fill_cnt_d;
    logic [W-1:0]    oldest;

    // The slot about to be overwritten holds the sample leaving the window.
    assign oldest   = buf_q[wr_ptr_q];
    assign sum_d    = sum_q + SW'(din_i) - SW'(oldest);
    assign wr_ptr_d = wr_ptr_q + 1'b1;

    // Saturates at DEPTH so it never wraps back into the "filling" range.
    assign fill_cnt_d = (fill_cnt_q == (LOG2+1)'(DEPTH)) ? fill_cnt_q : fill_cnt_q + 1'b1;

    assign avg_o       = sum_q[SW-1:LOG2];
    assign last_fill_o = (fill_cnt_q == (LOG2+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            fill_cnt_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            fill_cnt_q <= '0;
        end else if (wr_i) begin
            buf_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_d;
            sum_q           <= sum_d;
            fill_cnt_q      <= fill_cnt_d;
        end
    end

endmodule

// File: rtl/am_envelope_detector.sv
// AM envelope detector: offset-binary ADC samples -> rectifier -> moving average ->
// optional DC blocker -> DAC-format output, four pipeline stages.
module am_envelope_detector
    import am_pkg::*;
#(
    parameter int DIN_W    = 12,
    parameter int DOUT_W   = 14,
    parameter int AVG_LOG2 = 4,
    parameter int DC_SHIFT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [1:0]        mode_i,
    input  logic              dc_en_i,
    input  logic              in_valid_i,
    input  logic [DIN_W-1:0]  data_in_i,
    output logic              out_valid_o,
    output logic [DOUT_W-1:0] data_out_o,
    output logic              sat_o
);

    localparam int SHL = DOUT_W - DIN_W;
    localparam int DCW = DIN_W + DC_SHIFT;

    // Handshake: in_valid_i is a one-cycle strobe with no backpressure; out_valid_o is a
    // one-cycle pulse exactly AM_LAT clocks after the accepted strobe, data_out_o holds otherwise.

    // ---------------- control / flush ----------------
    am_mode_e  mode_n;
    am_mode_e  mode_cap_q;
    logic      dc_en_prev_q;
    logic      dc_toggle;
    logic      mode_chg;
    logic      flush;
    logic      accept;
    am_state_e state_q;
    am_state_e state_d;

    assign mode_n    = am_mode_norm(mode_i);
    assign dc_toggle = (dc_en_i != dc_en_prev_q);
    assign mode_chg  = in_valid_i && (mode_n != mode_cap_q);
    assign flush     = clr_i || mode_chg || dc_toggle;
    // A mode or dc_en change keeps the triggering sample as the first of the new fill.
    assign accept    = in_valid_i && !clr_i;

    // ---------------- pipeline registers ----------------
    logic                    s1_valid_q;
    logic signed [DIN_W-1:0] s1_x_q;
    am_mode_e                s1_mode_q;
    logic                    s1_dc_q;

    logic                    s2_valid_q;
    logic [DIN_W-1:0]        s2_m_q;
    logic                    s2_dc_q;

    logic                    s3_valid_q;
    logic                    s3_emit_q;
    logic                    s3_dc_q;

    logic                    out_valid_q;
    logic                    out_valid_d;
    logic [DOUT_W-1:0]       data_out_q;
    logic [DOUT_W-1:0]       data_out_d;
    logic                    sat_q;
    logic                    sat_d;
    logic [DCW-1:0]          dc_est_q;
    logic [DCW-1:0]          dc_est_d;

    // ---------------- S2 rectifier ----------------
    logic signed [2*DIN_W-1:0] sq;
    logic [2*DIN_W-1:0]        sq_shr;
    logic [DIN_W-1:0]          abs_x;
    logic [DIN_W-1:0]          m_d;

    always_comb begin
        sq     = (2*DIN_W)'(s1_x_q) * (2*DIN_W)'(s1_x_q);
        sq_shr = sq >> (DIN_W - 2);
        abs_x  = s1_x_q[DIN_W-1] ? $unsigned(-s1_x_q) : $unsigned(s1_x_q);
        m_d    = abs_x;
        case (s1_mode_q)
            MODE_HALF: m_d = s1_x_q[DIN_W-1] ? '0 : $unsigned(s1_x_q);
            // x = -2^(DIN_W-1) squares to exactly 2^DIN_W after the shift, hence the clamp.
            MODE_SQR:  m_d = (|sq_shr[2*DIN_W-1:DIN_W]) ? '1 : sq_shr[DIN_W-1:0];
            default:   m_d = abs_x;
        endcase
    end

    // ---------------- S3 moving average ----------------
    logic [DIN_W-1:0] avg;
    logic             last_fill;
    logic             s3_emit_d;

    am_movavg #(
        .W    (DIN_W),
        .LOG2 (AVG_LOG2)
    ) u_movavg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .wr_i        (s2_valid_q),
        .din_i       (s2_m_q),
        .avg_o       (avg),
        .last_fill_o (last_fill)
    );

    assign s3_emit_d = (state_q == ST_RUN) || last_fill;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FILL;
        end else if ((state_q == ST_FILL) && s2_valid_q && last_fill) begin
            state_d = ST_RUN;
        end
    end

    // ---------------- S4 output / DC blocker ----------------
    logic [DIN_W-1:0]      dc_mean;
    logic signed [DIN_W:0] y;
    logic                  clip;
    logic [DIN_W-1:0]      y_clip;
    logic [DCW-1:0]        dc_upd;

    always_comb begin
        dc_mean = dc_est_q[DCW-1:DC_SHIFT];
        y       = $signed({1'b0, avg}) - $signed({1'b0, dc_mean});
        // Out of range exactly when the two top bits of the wide difference disagree.
        clip    = (y[DIN_W] != y[DIN_W-1]);
        y_clip  = y[DIN_W-1:0];
        if (clip) begin
            y_clip = y[DIN_W] ? {1'b1, {(DIN_W-1){1'b0}}} : {1'b0, {(DIN_W-1){1'b1}}};
        end
        dc_upd  = dc_est_q + DCW'(avg) - DCW'(dc_mean);
    end

    always_comb begin
        out_valid_d = 1'b0;
        sat_d       = 1'b0;
        data_out_d  = data_out_q;
        dc_est_d    = dc_est_q;
        if (dc_toggle) begin
            dc_est_d = '0;
        end
        if (!flush && s3_valid_q && s3_emit_q) begin
            out_valid_d = 1'b1;
            if (s3_dc_q) begin
                // Flipping the sign bit turns two's complement into offset binary.
                data_out_d = DOUT_W'({~y_clip[DIN_W-1], y_clip[DIN_W-2:0]}) << SHL;
                sat_d      = clip;
                dc_est_d   = dc_upd;
            end else begin
                data_out_d = DOUT_W'(avg) << SHL;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            mode_cap_q   <= MODE_FULL;
            dc_en_prev_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_mode_q    <= MODE_FULL;
            s1_dc_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_m_q       <= '0;
            s2_dc_q      <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_emit_q    <= 1'b0;
            s3_dc_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            data_out_q   <= '0;
            sat_q        <= 1'b0;
            dc_est_q     <= '0;
        end else begin
            state_q      <= state_d;
            dc_en_prev_q <= dc_en_i;
            if (accept) begin
                mode_cap_q <= mode_n;
                s1_x_q     <= $signed({~data_in_i[DIN_W-1], data_in_i[DIN_W-2:0]});
                s1_mode_q  <= mode_n;
                s1_dc_q    <= dc_en_i;
            end
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q && !flush;
            s2_m_q     <= m_d;
            s2_dc_q    <= s1_dc_q;
            s3_valid_q <= s2_valid_q && !flush;
            s3_emit_q  <= s3_emit_d;
            s3_dc_q    <= s2_dc_q;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            sat_q       <= sat_d;
            dc_est_q    <= dc_est_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_out_o  = data_out_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_am_envelope_detector.sv
// Scoreboard bench for am_envelope_detector with an arithmetic reference model.
`timescale 1ns/1ps
module tb_am_envelope_detector;

    localparam int DIN_W    = 12;
    localparam int DOUT_W   = 14;
    localparam int AVG_LOG2 = 2;
    localparam int DC_SHIFT = 10;
    localparam int DEPTH    = 1 << AVG_LOG2;
    localparam int MID_IN   = 1 << (DIN_W - 1);
    localparam int LAT      = 4;
    localparam int EW       = 32 + 1 + DOUT_W;

    // ---------------- clock / reset / DUT ----------------
    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              clr      = 1'b0;
    logic [1:0]        mode     = 2'd0;
    logic              dc_en    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DIN_W-1:0]  data_in  = '0;
    logic              out_valid;
    logic [DOUT_W-1:0] data_out;
    logic              sat;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    am_envelope_detector #(
        .DIN_W    (DIN_W),
        .DOUT_W   (DOUT_W),
        .AVG_LOG2 (AVG_LOG2),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .mode_i      (mode),
        .dc_en_i     (dc_en),
        .in_valid_i  (in_valid),
        .data_in_i   (data_in),
        .out_valid_o (out_valid),
        .data_out_o  (data_out),
        .sat_o       (sat)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        int c;
        int x;
        int md;
        bit dc;
    } pend_t;

    pend_t             pend_q[$];
    int                win_q[$];
    logic [EW-1:0]     exp_q[$];
    int                fill;
    int                dc_est;
    int                mode_cap;
    bit                dc_prev;
    logic [DOUT_W-1:0] last_data;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        win_q.delete();
        exp_q.delete();
        fill      = 0;
        dc_est    = 0;
        mode_cap  = 0;
        dc_prev   = 1'b0;
        last_data = '0;
    endtask

    // A sample that survived its in-flight window: rectify, average, DC-block, predict output.
    task automatic commit(input pend_t p);
        int m, s, avg, dm, y, d;
        bit st;
        logic [EW-1:0] e;
        case (p.md)
            1:       m = (p.x > 0) ? p.x : 0;
            2:       m = (p.x * p.x) / (1 << (DIN_W - 2));
            default: m = (p.x < 0) ? -p.x : p.x;
        endcase
        if (m > (1 << DIN_W) - 1) m = (1 << DIN_W) - 1;
        win_q.push_back(m);
        if (win_q.size() > DEPTH) void'(win_q.pop_front());
        fill++;
        if (fill >= DEPTH) begin
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            avg = s / DEPTH;
            st  = 1'b0;
            if (!p.dc) begin
                d = avg * (1 << (DOUT_W - DIN_W));
            end else begin
                dm = dc_est / (1 << DC_SHIFT);
                y  = avg - dm;
                if (y > MID_IN - 1) begin y = MID_IN - 1; st = 1'b1; end
                if (y < -MID_IN)    begin y = -MID_IN;    st = 1'b1; end
                d = y * (1 << (DOUT_W - DIN_W)) + (1 << (DOUT_W - 1));
                dc_est = dc_est + avg - dm;
            end
            e = {32'(p.c + LAT), st, DOUT_W'(d)};
            exp_q.push_back(e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit c_clr, input int c_mode, input bit c_dc,
                         input bit c_vld, input int c_data);
        int t, mn;
        bit fl, acc;
        @(posedge clk);
        #1;
        clr      = c_clr;
        mode     = 2'(c_mode);
        dc_en    = c_dc;
        in_valid = c_vld;
        data_in  = DIN_W'(c_data);
        t   = cyc;
        mn  = (c_mode == 3) ? 0 : c_mode;
        acc = c_vld && !c_clr;
        fl  = c_clr || (c_vld && (mn != mode_cap)) || (c_dc != dc_prev);
        if (fl) begin
            pend_q.delete();
            win_q.delete();
            fill = 0;
            if (c_dc != dc_prev) dc_est = 0;
        end
        dc_prev = c_dc;
        if (acc) begin
            pend_q.push_back('{t, c_data - MID_IN, mn, c_dc});
            mode_cap = mn;
        end
        while (pend_q.size() > 0 && pend_q[0].c <= t - (LAT - 1)) begin
            commit(pend_q.pop_front());
        end
    endtask

    task automatic idle(input int n, input bit c_dc);
        for (int i = 0; i < n; i++) drive(1'b0, 0, c_dc, 1'b0, 0);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        dc_en    = 1'b0;
        mode     = 2'd0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset sat", int'(sat), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_e;
    int            mon_c;

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                mon_e = exp_q.pop_front();
                chk("missed output", cyc, int'(mon_e[EW-1 -: 32]));
            end
            mon_c = (exp_q.size() > 0) ? int'(exp_q[0][EW-1 -: 32]) : -1;
            if (mon_c == cyc) begin
                mon_e = exp_q.pop_front();
                chk("out_valid", int'(out_valid), 1);
                chk("data_out", int'(data_out), int'(mon_e[DOUT_W-1:0]));
                chk("sat", int'(sat), int'(mon_e[DOUT_W]));
                last_data = mon_e[DOUT_W-1:0];
            end else begin
                chk("spurious out_valid", int'(out_valid), 0);
                chk("data_out hold", int'(data_out), int'(last_data));
                chk("sat idle", int'(sat), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int cur_mode;
    bit cur_dc;

    initial begin
        model_reset();
        #1;
        apply_reset();

        // constant 3072 full-wave: fill of 3 silent samples then 4096
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b0, 1'b1, 3072);
        idle(6, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b0, 1'b1, 1024);
        for (int i = 0; i < 6; i++) drive(1'b0, 1, 1'b0, 1'b1, 1024);
        for (int i = 0; i < 6; i++) drive(1'b0, 1, 1'b0, 1'b1, 3072);
        for (int i = 0; i < 6; i++) drive(1'b0, 2, 1'b0, 1'b1, 3072);
        for (int i = 0; i < 6; i++) drive(1'b0, 2, 1'b0, 1'b1, 0);
        // reserved mode acts as full-wave; switching 3 -> 0 must not restart the fill
        for (int i = 0; i < 6; i++) drive(1'b0, 3, 1'b0, 1'b1, 1000);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b0, 1'b1, 1000 + 7 * i);
        // clr together with a sample drops it and restarts the fill
        drive(1'b1, 0, 1'b0, 1'b1, 3000);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b0, 1'b1, 500 + 300 * i);
        // mid-stream mode change in RUN
        for (int i = 0; i < 6; i++) drive(1'b0, 2, 1'b0, 1'b1, 3500 - 100 * i);
        // gapped samples and a bare clr
        for (int i = 0; i < 12; i++) drive(1'b0, 2, 1'b0, i[0], 2048 + 150 * i);
        drive(1'b1, 2, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) drive(1'b0, 2, 1'b0, 1'b1, 100 * i);
        idle(6, 1'b0);

        // DC blocker on a constant input: starts at 12288, decays toward 8192
        for (int i = 0; i < 1100; i++) drive(1'b0, 0, 1'b1, 1'b1, 3072);

        // randomized traffic
        cur_mode = 0;
        cur_dc   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 4) cur_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 2) cur_dc = ~cur_dc;
            drive(($urandom_range(0, 99) < 3), cur_mode, cur_dc,
                  ($urandom_range(0, 99) < 75), $urandom_range(0, 4095));
        end
        idle(6, 1'b0);

        // back-to-back burst with a reset in the middle
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 0, 1'b0, 1'b1, $urandom_range(0, 4095));
            if (i == 11) begin
                #2;
                apply_reset();
            end
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 1, 1'b0, 1'b1, $urandom_range(0, 4095));
        idle(8, 1'b0);

        chk("outputs outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am_envelope_detector.md
Name: am_envelope_detector

Overview:
- Parametrised AM envelope detector: ADC samples (offset binary) → selectable rectifier → moving-average LPF → optional DC blocker → DAC-format output.
- Replaces the fixed full-wave-rectifier-plus-FIR-IP demodulator path.
- Sits between the ADC capture logic (which supplies a one-cycle in_valid strobe in the clk domain) and the DAC driver.

Parameters:
- DIN_W, 12, ADC sample width, offset binary, midscale 2^(DIN_W-1).
- DOUT_W, 14, DAC output width; must be >= DIN_W.
- AVG_LOG2, 4, moving-average depth = 2^AVG_LOG2 samples (1..8).
- DC_SHIFT, 10, DC-blocker leaky-integrator time constant = 2^DC_SHIFT samples.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- clr  in  1  synchronous flush, single-cycle pulse.
- mode  in  2  0 = full-wave abs, 1 = half-wave, 2 = square-law, 3 = reserved (treated as 0).
- dc_en  in  1  enables the DC blocker.
- in_valid  in  1  one-cycle sample strobe; back-to-back allowed.
- data_in  in  DIN_W  ADC sample, offset binary.
- out_valid  out  1  one-cycle pulse per output sample.
- data_out  out  DOUT_W  envelope; held between out_valid pulses.
- sat  out  1  high with out_valid when this output was clipped.

Behaviour:
- Reset: out_valid=0, data_out=0, sat=0; buffer, sum, dc_est and counters = 0; FSM = FILL.
- Pipeline, 4 stages, each advancing on its valid bit. out_valid rises exactly 4 clk after the in_valid it belongs to.
- S1: x = data_in - 2^(DIN_W-1), signed DIN_W bits. Capture mode and dc_en with the sample.
- S2 rectify to unsigned m, DIN_W bits:
  - Full-wave: m = |x|.
  - Half-wave: m = x>0 ? x : 0.
  - Square-law: m = (x*x) >> (DIN_W-2), saturated to 2^DIN_W-1.
- S3 moving average:
  - Circular buffer of 2^AVG_LOG2 entries; write pointer wraps modulo depth.
  - sum (DIN_W+AVG_LOG2 bits) <= sum + m - oldest.
  - avg = sum >> AVG_LOG2.
- S4 output:
  - dc_en=0: data_out = avg << (DOUT_W-DIN_W).
  - dc_en=1:
    - dc_est (DIN_W+DC_SHIFT bits) <= dc_est + avg - (dc_est>>DC_SHIFT).
    - y = avg - (dc_est>>DC_SHIFT), computed with the pre-update dc_est.
    - Clip y to [-2^(DIN_W-1), 2^(DIN_W-1)-1]; sat=1 if clipped.
    - data_out = (y << (DOUT_W-DIN_W)) + 2^(DOUT_W-1).
- FSM, FILL / RUN:
  - FILL: samples enter the buffer; out_valid suppressed; data_out holds its last value. A fill counter counts S3 writes. After the 2^AVG_LOG2-th write, go to RUN; that sample's output is the first out_valid.
  - RUN: every sample produces an output.
  - Any state → FILL, in the same cycle, on:
    - clr=1;
    - mode at S1 differing from the previous captured mode;
    - dc_en toggling. This also zeroes dc_est.
  - FILL entry zeroes the buffer, sum and fill counter. In-flight S2–S4 samples are discarded, with no out_valid.
- Simultaneous clr and in_valid: clr wins; the sample is dropped.
- Reset mid-operation: immediate return to the reset state; no partial output.

Decomposition:
- Shared package am_pkg:
  - mode encodings MODE_FULL/MODE_HALF/MODE_SQR;
  - pipeline latency constant AM_LAT=4;
  - FSM state enum.
- One natural sub-module: am_movavg (circular buffer, running sum, fill counter; parameters W, LOG2).

Test Plan (DIN_W=12, DOUT_W=14, AVG_LOG2=2, DC_SHIFT=10):
- Constant data_in=3072, mode 0, 8 samples → no out_valid for samples 1–3. Outputs begin 4 clk after sample 4, each data_out=4096, sat=0.
- data_in=1024 in mode 0 → 4096. Same input in mode 1 → 0. data_in=3072 in mode 1 → 4096.
- Mode 2:
  - data_in=3072 (x=1024) → avg 1024, data_out=4096.
  - data_in=0 (x=-2048) → m saturates to 4095, data_out=16380.
- dc_en=1, constant data_in=3072, mode 0:
  - first output 12288;
  - output decays monotonically toward 8192 over ~2^10 samples;
  - sat=0 throughout.
- After RUN is reached, change mode 0→2 mid-stream → next 3 samples produce no out_valid. The 4th does, with the square-law value. clr together with in_valid → that sample is dropped and the fill restarts.
- Back-to-back in_valid for 16 cycles → one out_valid per cycle once in RUN, each at exactly 4 clk latency. Assert rst_n low mid-burst → out_valid=0 and data_out=0 immediately.
